// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter and select controller for the shared
// 4:1 mux. It grants one of four sources (a,b,c,d) at a time, drives the mux
// selects {s1,s2}, and registers the selected data with a valid flag.
// Optional feature: define MUX4_ARB_TIMEOUT_EN to bound grant tenure to
// HOLD_MAX cycles whenever another source is waiting.
module mux4_rr_arbiter #(
   parameter int DATA_W   = 1,
   parameter int HOLD_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   output logic [3:0]        gnt,
   output logic              s1,
   output logic              s2,
   output logic [DATA_W-1:0] out,
   output logic              valid,
   output logic              busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t            r_state;
   logic [1:0]        r_last;      // most recently granted index (owner while in GRANT)
   logic [3:0]        r_gnt;
   logic              r_s1;
   logic              r_s2;
   logic [DATA_W-1:0] r_out;
   logic              r_valid;
   logic              r_busy;

   logic [3:0]        w_owner_mask;
   logic [3:0]        w_cand;
   logic              w_release;
   logic              w_preempt;
   logic              w_rearb;
   logic              w_found;
   logic              w_take;
   logic [1:0]        w_win;
   logic [1:0]        w_idx;
   logic [1:0]        w_load_idx;
   logic [DATA_W-1:0] w_load_data;

   assign w_owner_mask = 4'b0001 << r_last;
   assign w_release    = (r_state == ST_GRANT) && !req[r_last];
   assign w_rearb      = (r_state == ST_IDLE) || w_release || w_preempt;

   // While someone owns the bus, a re-arbitration must pick a different source.
   assign w_cand = (r_state == ST_GRANT) ? (req & ~w_owner_mask) : req;

   // Round-robin search: last+1, last+2, last+3, then last itself.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_last;
      w_idx   = r_last;
      for (int k = 1; k <= 4; k++) begin
         w_idx = r_last + 2'(k);
         if (!w_found && w_cand[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_take     = w_rearb && w_found;
   assign w_load_idx = w_take ? w_win : r_last;

   // Data that out captures this edge: the new winner on a grant, else the owner.
   always_comb begin
      case (w_load_idx)
         2'd0:    w_load_data = a;
         2'd1:    w_load_data = b;
         2'd2:    w_load_data = c;
         default: w_load_data = d;
      endcase
   end

`ifdef MUX4_ARB_TIMEOUT_EN
   localparam logic [7:0] TEN_LIM = 8'(HOLD_MAX - 1);

   logic [7:0] r_ten;

   // Preempt only when the tenure limit is reached and someone else is waiting.
   assign w_preempt = (r_state == ST_GRANT) && (r_ten == TEN_LIM) && |(req & ~w_owner_mask);

   // Tenure counter: cleared by each new grant, saturates at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ten <= 8'd0;
      end else if (w_take) begin
         r_ten <= 8'd0;
      end else if ((r_state == ST_GRANT) && (r_ten != TEN_LIM)) begin
         r_ten <= r_ten + 8'd1;
      end
   end
`else
   // Without the tenure counter the owner is never preempted; HOLD_MAX has no effect.
   assign w_preempt = 1'b0 && (HOLD_MAX != 0);
`endif

   // Grant FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_last  <= 2'd3;
         r_gnt   <= 4'b0000;
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  r_state      <= ST_GRANT;
                  r_last       <= w_win;
                  r_gnt        <= 4'b0001 << w_win;
                  {r_s1, r_s2} <= w_win;
                  r_out        <= w_load_data;
                  r_valid      <= 1'b1;
                  r_busy       <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (w_take) begin
                  // direct handover, no idle bubble
                  r_last       <= w_win;
                  r_gnt        <= 4'b0001 << w_win;
                  {r_s1, r_s2} <= w_win;
                  r_out        <= w_load_data;
                  r_valid      <= 1'b1;
               end else if (w_rearb) begin
                  // owner released and nobody else waits; selects keep their value
                  r_state <= ST_IDLE;
                  r_gnt   <= 4'b0000;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
               end else begin
                  r_out <= w_load_data;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gnt   = r_gnt;
   assign s1    = r_s1;
   assign s2    = r_s2;
   assign out   = r_out;
   assign valid = r_valid;
   assign busy  = r_busy;

endmodule
